// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared CPU divider definitions: state encoding and operand width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider, one quotient bit per cycle,
// result {remainder, quotient}; busy stalls the upstream pipeline while a divide is in flight.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_div,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             last_iter;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_abs = a_neg ? (~a + 1'b1) : a;
  assign b_abs = b_neg ? (~b + 1'b1) : b;

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};

  // Negation wraps modulo 2^WIDTH, so the most-negative / -1 case falls out without a trap.
  assign q_fin = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign r_fin = neg_r ? (~rem_nx + 1'b1) : rem_nx;

  assign last_iter = (iter == CW'(WIDTH - 1));

  assign busy = ~rst & (((state == ST_IDLE) & start & ~annul) | (state == ST_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      iter   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (annul) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (b == '0) begin
                state  <= ST_DONE;
                result <= {a, {WIDTH{1'b1}}};
                ready  <= 1'b1;
              end else begin
                state <= ST_DIV;
                quo   <= a_abs;
                dvs   <= b_abs;
                rem   <= '0;
                iter  <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
              end
            end
          end
          ST_DIV: begin
            quo  <= quo_nx;
            rem  <= rem_nx;
            iter <= iter + CW'(1);
            if (last_iter) begin
              state  <= ST_DONE;
              result <= {r_fin, q_fin};
              ready  <= 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
